// File: rtl/fpu_issue_arb_if.sv
// Handshake bundle between the requesters, the shared-FPU issue arbiter and the FPU itself.
// master = arbiter side, slave = requesters/FPU side.
interface fpu_issue_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned REQ_W = 128,
    parameter int unsigned ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*REQ_W-1:0] req_data;
    logic                  fpu_valid_i;
    logic [REQ_W-1:0]      fpu_data;
    logic [ID_W-1:0]       fpu_user_i;
    logic                  fpu_ready_o;
    logic                  fpu_valid_o;
    logic [ID_W-1:0]       fpu_user_o;
    logic                  fpu_stall_i;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic                  tag_err;

    modport master (
        input  req_valid, req_data, fpu_ready_o, fpu_valid_o, fpu_user_o, rsp_ready,
        output req_ready, fpu_valid_i, fpu_data, fpu_user_i, fpu_stall_i, rsp_valid, tag_err
    );

    modport slave (
        output req_valid, req_data, fpu_ready_o, fpu_valid_o, fpu_user_o, rsp_ready,
        input  req_ready, fpu_valid_i, fpu_data, fpu_user_i, fpu_stall_i, rsp_valid, tag_err
    );
endinterface

// File: rtl/fpu_issue_arb.sv
// Round-robin issue arbiter sharing one FPU between NREQ requesters, with per-requester credits
// and tag-based result steering. Define FPU_ARB_PRIO_EN to give requester 0 fixed top priority.
module fpu_issue_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned REQ_W     = 128,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned MAX_OUTST = 3
) (
    input  logic            clk,
    input  logic            rst,
    fpu_issue_arb_if.master bus
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q [NREQ];
    logic [CNT_W-1:0] cnt_d [NREQ];
    logic             valid_q, valid_d;
    logic [REQ_W-1:0] data_q, data_d;
    logic [ID_W-1:0]  user_q, user_d;
    logic             tag_err_q, tag_err_d;

    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] winner;
    logic [REQ_W-1:0] win_data;
    logic             load;
    logic             accept;

    logic             tag_live;
    logic             tag_rdy;
    logic             good;
    logic             rsp_hs;
    logic             bad_tag;

    // Winner search starts at ptr and wraps; credit-exhausted requesters are skipped.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] && (cnt_q[i] < CNT_MAX);
        end
        found  = 1'b0;
        idx    = '0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PTR_W'((32'(ptr_q) + k) % NREQ);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef FPU_ARB_PRIO_EN
        if (eligible[0]) begin
            winner = '0;
        end
`endif
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_data = bus.req_data[i*REQ_W +: REQ_W];
            end
        end
    end

    assign load   = ~valid_q | bus.fpu_ready_o;
    assign accept = load & found & ~rst;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept && (winner == PTR_W'(i))) begin
                bus.req_ready[i] = 1'b1;
            end
        end
    end

    // A tag is live only if it names a real requester that still has an op in flight.
    always_comb begin
        tag_live = 1'b0;
        tag_rdy  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(bus.fpu_user_o) == i) begin
                tag_live = (cnt_q[i] != '0);
                tag_rdy  = bus.rsp_ready[i];
            end
        end
        good    = bus.fpu_valid_o & tag_live & ~rst;
        rsp_hs  = good & tag_rdy;
        bad_tag = bus.fpu_valid_o & ~tag_live;

        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.rsp_valid[i] = good && (32'(bus.fpu_user_o) == i);
        end
        bus.fpu_stall_i = good & ~tag_rdy;
    end

    always_comb begin
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        user_d    = user_q;
        tag_err_d = tag_err_q | bad_tag;
        if (load) begin
            valid_d = accept;
            if (accept) begin
                data_d = win_data;
                user_d = ID_W'(winner);
`ifdef FPU_ARB_PRIO_EN
                if (winner != '0) begin
                    ptr_d = PTR_W'((32'(winner) + 1) % NREQ);
                end
`else
                ptr_d = PTR_W'((32'(winner) + 1) % NREQ);
`endif
            end
        end

        // Simultaneous accept and result for the same requester cancel out.
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((accept && (winner == PTR_W'(i))) &&
                !(rsp_hs && (32'(bus.fpu_user_o) == i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!(accept && (winner == PTR_W'(i))) &&
                         (rsp_hs && (32'(bus.fpu_user_o) == i))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            user_q    <= '0;
            tag_err_q <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            user_q    <= user_d;
            tag_err_q <= tag_err_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.fpu_valid_i = valid_q;
    assign bus.fpu_data    = data_q;
    assign bus.fpu_user_i  = user_q;
    assign bus.tag_err     = tag_err_q;
endmodule

// File: tb/tb_fpu_issue_arb.sv
// Self-checking bench for fpu_issue_arb: transaction-level model with a per-cycle compare
// process, directed scenarios with literal expectations, and a randomized soak.
module tb_fpu_issue_arb;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned REQ_W     = 128;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned MAX_OUTST = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_issue_arb_if #(.NREQ(NREQ), .REQ_W(REQ_W), .ID_W(ID_W)) bus ();

    fpu_issue_arb #(
        .NREQ(NREQ), .REQ_W(REQ_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: outstanding ops per requester, RR pointer, contents of the issue slot.
    int               m_cnt [NREQ];
    int               m_ptr;
    bit               m_v;
    logic [REQ_W-1:0] m_data;
    int               m_user;
    bit               m_err;
    int               pend[$];
    int               issue_log[$];

    bit ret_en   = 1'b0;
    int ret_pct  = 100;
    bit rnd_mode = 1'b0;

    int               acc;
    logic [REQ_W-1:0] d0;
    int               u0;

    task automatic chk(input string name, input logic [REQ_W-1:0] act,
                       input logic [REQ_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int win, j, tag;
        bit any, ld, tag_ok, hs, done;
        logic [NREQ-1:0] e_rr, e_rv;
        bit e_st;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ptr = 0; m_v = 0; m_data = '0; m_user = 0; m_err = 0;
            pend.delete();
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_stall", bus.fpu_stall_i, 0);
            chk("rst_valid_i", bus.fpu_valid_i, 0);
            chk("rst_data", bus.fpu_data, 0);
            chk("rst_user_i", bus.fpu_user_i, 0);
            chk("rst_tag_err", bus.tag_err, 0);
        end else begin
            any = 0; win = 0;
`ifdef FPU_ARB_PRIO_EN
            if (bus.req_valid[0] && m_cnt[0] < MAX_OUTST) begin any = 1; win = 0; end
`endif
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!any && bus.req_valid[j] && m_cnt[j] < MAX_OUTST) begin any = 1; win = j; end
            end
            ld   = !m_v || bus.fpu_ready_o;
            e_rr = (ld && any) ? (NREQ'(1) << win) : '0;
            tag  = int'(bus.fpu_user_o);
            tag_ok = (tag < NREQ) && (m_cnt[tag] > 0);
            e_rv = (bus.fpu_valid_o && tag_ok) ? (NREQ'(1) << tag) : '0;
            e_st = bus.fpu_valid_o && tag_ok && !bus.rsp_ready[tag];
            hs   = bus.fpu_valid_o && tag_ok && bus.rsp_ready[tag];

            chk("req_ready", bus.req_ready, e_rr);
            chk("rsp_valid", bus.rsp_valid, e_rv);
            chk("fpu_stall_i", bus.fpu_stall_i, e_st);
            chk("fpu_valid_i", bus.fpu_valid_i, m_v);
            chk("tag_err", bus.tag_err, m_err);
            if (m_v) begin
                chk("fpu_data", bus.fpu_data, m_data);
                chk("fpu_user_i", bus.fpu_user_i, m_user);
                if (bus.fpu_ready_o) pend.push_back(m_user);
            end
            if (bus.fpu_valid_i && bus.fpu_ready_o) issue_log.push_back(int'(bus.fpu_user_i));

            if (hs) begin
                m_cnt[tag]--;
                done = 0;
                for (int i = 0; i < pend.size(); i++) begin
                    if (!done && pend[i] == tag) begin pend.delete(i); done = 1; end
                end
            end
            if (bus.fpu_valid_o && !tag_ok) m_err = 1;
            if (ld) begin
                if (any) begin
                    m_cnt[win]++;
                    m_v    = 1;
                    m_data = bus.req_data[win*REQ_W +: REQ_W];
                    m_user = win;
`ifdef FPU_ARB_PRIO_EN
                    if (win != 0) m_ptr = (win + 1) % NREQ;
`else
                    m_ptr = (win + 1) % NREQ;
`endif
                end else begin
                    m_v = 0;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            bus.req_valid = NREQ'($urandom());
            for (int i = 0; i < NREQ; i++)
                bus.req_data[i*REQ_W +: REQ_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.fpu_ready_o = ($urandom_range(3) != 0);
            bus.rsp_ready   = NREQ'($urandom() | $urandom());
        end
        if (ret_en) begin
            if (pend.size() > 0 && $urandom_range(99) < ret_pct) begin
                bus.fpu_valid_o = 1'b1;
                bus.fpu_user_o  = ID_W'(pend[0]);
            end else begin
                bus.fpu_valid_o = 1'b0;
            end
        end
    endtask

    task automatic drain();
        bus.req_valid = '0; bus.fpu_ready_o = 1'b1; bus.rsp_ready = '1;
        ret_en = 1; ret_pct = 100; rnd_mode = 0;
        for (int n = 0; n < 60 && (pend.size() > 0 || m_v); n++) cycle();
        ret_en = 0;
        bus.fpu_valid_o = 1'b0;
        chk("drain", pend.size() + int'(m_v), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '1; bus.fpu_ready_o = 1'b1; bus.fpu_valid_o = 1'b0;
        bus.fpu_user_o = '0; bus.rsp_ready = '1;
        for (int i = 0; i < NREQ; i++)
            bus.req_data[i*REQ_W +: REQ_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1 rst = 1'b1;
        #2;
        chk("reset_gate_req_ready", bus.req_ready, 0);
        chk("reset_valid_i", bus.fpu_valid_i, 0);
        chk("reset_tag_err", bus.tag_err, 0);
        cycle();
`ifdef FPU_ARB_PRIO_EN
        ret_en = 0;
`else
        ret_en = 1; ret_pct = 100;
`endif
        cycle();
        rst = 1'b0;
`ifdef FPU_ARB_PRIO_EN
        bus.req_valid = 4'b0111;
`else
        bus.req_valid = 4'b1111;
`endif
        #2;
        chk("first_accept", bus.req_ready, 4'b0001);
        chk("no_issue_yet", bus.fpu_valid_i, 0);
        d0 = bus.req_data[0 +: REQ_W];
        cycle(); #2;
        chk("first_issue_valid", bus.fpu_valid_i, 1);
        chk("first_issue_user", bus.fpu_user_i, 0);
        chk("first_issue_data", bus.fpu_data, d0);
`ifdef FPU_ARB_PRIO_EN
        chk("prio_second", bus.req_ready, 4'b0001);
        repeat (12) cycle();
        begin
            int prio_exp [9] = '{0, 0, 0, 1, 2, 1, 2, 1, 2};
            chk("prio_count", issue_log.size(), 9);
            for (int i = 0; i < 9 && i < issue_log.size(); i++)
                chk("prio_order", issue_log[i], prio_exp[i]);
        end
`else
        chk("rr_second", bus.req_ready, 4'b0010);
        repeat (8) cycle();
        chk("rr_count", issue_log.size() >= 8, 1);
        for (int i = 0; i < 8 && i < issue_log.size(); i++)
            chk("rr_order", issue_log[i], i % 4);
`endif
        drain();

        // Credit limit on a lone requester.
        acc = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(); bus.req_valid = 4'b0100; #2;
            if (bus.req_ready[2]) acc++;
        end
        chk("outst_accepts", acc, 3);
        chk("outst_block", bus.req_ready, 0);
        cycle(); bus.fpu_valid_o = 1'b1; bus.fpu_user_o = 2; bus.rsp_ready = '1; #2;
        chk("credit_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("credit_same_cycle", bus.req_ready, 0);
        cycle(); bus.fpu_valid_o = 1'b0; #2;
        chk("credit_return", bus.req_ready, 4'b0100);
        drain();

        // FPU input back-pressure.
        ret_en = 1; ret_pct = 100;
        for (int n = 0; n < 6; n++) begin cycle(); bus.req_valid = '1; end
        cycle(); bus.fpu_ready_o = 1'b0; #2;
        chk("hold_valid", bus.fpu_valid_i, 1);
        chk("hold_req_ready", bus.req_ready, 0);
        d0 = m_data; u0 = m_user;
        for (int n = 0; n < 4; n++) begin
            cycle(); bus.fpu_ready_o = 1'b0;
            for (int i = 0; i < NREQ; i++)
                bus.req_data[i*REQ_W +: REQ_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
            #2;
            chk("hold_data", bus.fpu_data, d0);
            chk("hold_user", bus.fpu_user_i, u0);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        cycle(); bus.fpu_ready_o = 1'b1; #2;
        chk("reload_onehot", $countones(bus.req_ready), 1);
        drain();

        // Result back-pressure keeps the credit held.
        for (int n = 0; n < 3; n++) begin
            cycle(); bus.req_valid = 4'b0010; #2;
            chk("p4_fill", bus.req_ready, 4'b0010);
        end
        for (int n = 0; n < 3; n++) begin
            cycle(); bus.fpu_valid_o = 1'b1; bus.fpu_user_o = 1; bus.rsp_ready = 4'b1101; #2;
            chk("stall_on", bus.fpu_stall_i, 1);
            chk("stall_rsp_valid", bus.rsp_valid, 4'b0010);
            chk("stall_cnt_held", bus.req_ready, 0);
        end
        cycle(); bus.rsp_ready = '1; #2;
        chk("stall_off", bus.fpu_stall_i, 0);
        chk("stall_off_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("stall_off_ready", bus.req_ready, 0);
        cycle(); bus.fpu_valid_o = 1'b0; #2;
        chk("stall_release_credit", bus.req_ready, 4'b0010);
        drain();

        // Accept and result for the same requester in one cycle.
        for (int n = 0; n < 2; n++) begin
            cycle(); bus.req_valid = 4'b0010; #2;
            chk("same_fill", bus.req_ready, 4'b0010);
        end
        cycle(); bus.fpu_valid_o = 1'b1; bus.fpu_user_o = 1; bus.rsp_ready = '1; #2;
        chk("same_accept", bus.req_ready, 4'b0010);
        chk("same_rsp", bus.rsp_valid, 4'b0010);
        cycle(); bus.fpu_valid_o = 1'b0; #2;
        chk("same_then_accept", bus.req_ready, 4'b0010);
        cycle(); #2;
        chk("same_then_full", bus.req_ready, 0);
        drain();

        // Result for a requester with nothing outstanding.
        cycle(); bus.fpu_valid_o = 1'b1; bus.fpu_user_o = 3; #2;
        chk("badtag_rsp_valid", bus.rsp_valid, 0);
        chk("badtag_stall", bus.fpu_stall_i, 0);
        cycle(); bus.fpu_valid_o = 1'b0; #2;
        chk("badtag_err", bus.tag_err, 1);
        repeat (3) cycle();
        #2 chk("badtag_sticky", bus.tag_err, 1);
        cycle(); rst = 1'b1; #2;
        chk("err_clear", bus.tag_err, 0);
        cycle(); rst = 1'b0;

        // Randomized soak with a mid-burst reset and a stale result afterwards.
        rnd_mode = 1; ret_en = 1; ret_pct = 60;
        repeat (1200) cycle();
        cycle(); rst = 1'b1; #2;
        chk("mid_rst_valid_i", bus.fpu_valid_i, 0);
        chk("mid_rst_tag_err", bus.tag_err, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        cycle(); rst = 1'b0; rnd_mode = 0; ret_en = 0;
        bus.fpu_valid_o = 1'b1; bus.fpu_user_o = 2; #2;
        chk("stale_rsp_valid", bus.rsp_valid, 0);
        chk("stale_stall", bus.fpu_stall_i, 0);
        cycle(); bus.fpu_valid_o = 1'b0; #2;
        chk("stale_tag_err", bus.tag_err, 1);
        rnd_mode = 1; ret_en = 1;
        repeat (200) cycle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_issue_arb.md
Name: fpu_issue_arb

Overview:
- Shares one FPU instance between NREQ requesters.
- Round-robin arbitrates requests into a single registered issue stage feeding the FPU input handshake (valid_i/ready_o).
- Tags each operation with the requester ID on the FPU user_i field, limits outstanding operations per requester with credit counters, and steers the FPU's result handshake (valid_o/user_o/stall_i) back to the owning requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- REQ_W, 128, packed request payload width: op, fn, rm, operands, concatenated by the requester
- ID_W, 2, tag width; must be at least clog2(NREQ) and no greater than the FPU user width
- MAX_OUTST, 3, maximum in-flight operations per requester (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept
- req_data  in  NREQ*REQ_W  per-requester payload; slice i = bits [i*REQ_W +: REQ_W]
- fpu_valid_i  out  1  to FPU valid_i
- fpu_data  out  REQ_W  to FPU operand/op/rm/fn inputs
- fpu_user_i  out  ID_W  to FPU user_i (requester tag)
- fpu_ready_o  in  1  from FPU ready_o
- fpu_valid_o  in  1  from FPU valid_o
- fpu_user_o  in  ID_W  from FPU user_o (returned tag)
- fpu_stall_i  out  1  to FPU stall_i
- rsp_valid  out  NREQ  one-hot result valid; result/fflags bus is wired directly from the FPU
- rsp_ready  in  NREQ  per-requester result accept
- tag_err  out  1  sticky: result returned with tag >= NREQ or to a requester with zero count

Behaviour:
Reset (async, rst=1):
- fpu_valid_i=0, fpu_data=0, fpu_user_i=0, tag_err=0.
- RR pointer=0, all credit counts=0.
- req_ready=0, fpu_stall_i=0, rsp_valid=0 while rst=1.

Issue stage (one register):
- `load = ~fpu_valid_i | fpu_ready_o`.
- Requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUTST.
- Winner = first eligible index at or after ptr, wrapping modulo NREQ.
- req_ready[winner] = load; all other bits are 0. Only one requester is accepted per cycle.
- On acceptance, next cycle: fpu_valid_i=1, fpu_data=req_data[winner], fpu_user_i=winner, ptr=(winner+1) mod NREQ.
- If load=1 and nothing is eligible: fpu_valid_i drops to 0 and ptr is unchanged.
- While fpu_valid_i=1 and fpu_ready_o=0: the register holds and req_ready is all 0.
- Latency from request accept to fpu_valid_i is 1 cycle. Throughput is 1 op/cycle while the FPU stays ready.

Credits:
- cnt[i] increments on request accept and decrements on result handshake for i.
- Both in the same cycle: cnt[i] is unchanged.
- cnt never wraps; the eligibility gate prevents overflow.

Return path:
- rsp_valid[k] = fpu_valid_o when k = fpu_user_o and k < NREQ.
- fpu_stall_i = fpu_valid_o & ~rsp_ready[fpu_user_o]. Back-pressure is propagated combinationally, same cycle.
- Result handshake = fpu_valid_o & rsp_ready[fpu_user_o] & ~fpu_stall_i.
- Bad tag (fpu_user_o >= NREQ, or cnt of the tagged requester = 0):
  - set tag_err;
  - rsp_valid all 0, fpu_stall_i=0, so the result is dropped;
  - no cnt change.

Reset mid-operation: all state clears immediately; in-flight FPU results after reset are treated as bad tags (cnt=0) and set tag_err.

Optional Feature:
FPU_ARB_PRIO_EN
- Defined: requester 0 has fixed highest priority whenever eligible; the remaining requesters round-robin as above. Winning requester 0 does not move ptr.
- Undefined: pure round-robin across all NREQ requesters.

Test Plan:
- Reset, then req_valid=4'b1111 every cycle, fpu_ready_o=1, results returned with rsp_ready=1 → issue order 0,1,2,3,0,1… with fpu_user_i matching; fpu_valid_i first high 1 cycle after first accept.
- Only requester 2 valid, results withheld (fpu_valid_o=0) → exactly 3 accepts (MAX_OUTST=3), then req_ready[2]=0; one result with user_o=2 → req_ready[2] returns next cycle.
- fpu_ready_o=0 for 5 cycles with fpu_valid_i=1 → fpu_data/fpu_user_i stable, req_ready=0; fpu_ready_o=1 → next winner loaded same edge.
- fpu_valid_o=1, user_o=1, rsp_ready[1]=0 for 3 cycles → fpu_stall_i=1, rsp_valid=4'b0010, cnt[1] unchanged; rsp_ready[1]=1 → stall drops, cnt[1] decrements.
- Same cycle: accept from requester 1 and result for requester 1 → cnt[1] unchanged; fpu_user_o=3 with cnt[3]=0 → tag_err=1, stays 1 until rst.
- FPU_ARB_PRIO_EN defined, req_valid=4'b0111 continuous → requester 0 wins until cnt[0]=3, then 1,2 alternate; assert rst mid-burst → fpu_valid_i=0, tag_err=0, counts 0 asynchronously.
